tetris_vga_render: RTL and testbench

- Downstream display stage for the tetris board memory. Generates 640x480@60 VGA timing and drives the board memory read address.
- Maps each board pixel to its cell colour returned on the memory read port. Adds a cell grid and a white border, and emits RGB444 with syncs.
- Also issues a once-per-frame tick for game timing.

---
 rtl/tetris_vga_render.sv | 200 ++++++++++++++++++++
 tb/tb_tetris_vga_render.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/tetris_vga_render.sv
// VGA raster generator for the tetris board: timing counters, board memory addressing,
// grid/border overlay and frame tick, with every output aligned three clocks after its counter sample.
module tetris_vga_render #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int CELL       = 20,
    parameter int COLS       = 10,
    parameter int ROWS       = 21,
    parameter int BOARD_X0   = 220,
    parameter int BOARD_Y0   = 30,
    parameter int BORDER_W   = 2,
    parameter int BLANK_ADDR = 210
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] mem_dout,
    output logic [8:0]  addr_r,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic        frame_tick
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int PW      = (CELL > 1) ? $clog2(CELL) : 1;
    localparam int CXW     = $clog2(COLS + 1);
    localparam int CYW     = $clog2(ROWS + 1);
    localparam int RBW     = $clog2(ROWS * COLS + 1);

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_BX0  = HW'(BOARD_X0);
    localparam logic [HW-1:0] H_BX1  = HW'(BOARD_X0 + COLS * CELL);
    localparam logic [HW-1:0] H_BL0  = HW'(BOARD_X0 - BORDER_W);
    localparam logic [HW-1:0] H_BL1  = HW'(BOARD_X0 + COLS * CELL + BORDER_W);
    localparam logic [HW-1:0] H_S0   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_S1   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_BY0  = VW'(BOARD_Y0);
    localparam logic [VW-1:0] V_BY1  = VW'(BOARD_Y0 + ROWS * CELL);
    localparam logic [VW-1:0] V_BL0  = VW'(BOARD_Y0 - BORDER_W);
    localparam logic [VW-1:0] V_BL1  = VW'(BOARD_Y0 + ROWS * CELL + BORDER_W);
    localparam logic [VW-1:0] V_S0   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_S1   = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [PW-1:0] P_LAST = PW'(CELL - 1);

    // Per-pixel controls carried alongside the memory read so they line up with mem_dout.
    typedef struct packed {
        logic act;
        logic inb;
        logic grid;
        logic bord;
        logic hs;
        logic vs;
        logic ft;
    } ctl_t;

    localparam ctl_t CTL_IDLE = '{act: 1'b0, inb: 1'b0, grid: 1'b0, bord: 1'b0,
                                  hs: 1'b1, vs: 1'b1, ft: 1'b0};

    logic [HW-1:0]  hcnt_q, hcnt_d;
    logic [VW-1:0]  vcnt_q, vcnt_d;
    logic [PW-1:0]  px_q, px_d, py_q, py_d;
    logic [CXW-1:0] cx_q, cx_d;
    logic [CYW-1:0] cy_q, cy_d;
    logic [RBW-1:0] rb_q, rb_d;
    logic [8:0]     addr_q, addr_d;
    ctl_t           ctl0, ctl1_q, ctl2_q;
    logic [11:0]    rgb_q, rgb_d;
    logic           hs_q, vs_q, de_q, ft_q;
    logic           line_end, h_in, v_in;

    always_comb begin
        line_end = (hcnt_q == H_LAST);
        h_in     = (hcnt_q >= H_BX0) && (hcnt_q < H_BX1);
        v_in     = (vcnt_q >= V_BY0) && (vcnt_q < V_BY1);

        hcnt_d = line_end ? '0 : hcnt_q + HW'(1);
        vcnt_d = vcnt_q;
        if (line_end) begin
            vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + VW'(1);
        end

        // Cell position is tracked incrementally so no divider is needed on the pixel path.
        px_d = px_q;
        cx_d = cx_q;
        if (hcnt_d == H_BX0) begin
            px_d = '0;
            cx_d = '0;
        end else if (h_in) begin
            if (px_q == P_LAST) begin
                px_d = '0;
                cx_d = cx_q + CXW'(1);
            end else begin
                px_d = px_q + PW'(1);
            end
        end

        py_d = py_q;
        cy_d = cy_q;
        rb_d = rb_q;
        if (line_end) begin
            if (vcnt_d == V_BY0) begin
                py_d = '0;
                cy_d = '0;
                rb_d = '0;
            end else if (v_in) begin
                if (py_q == P_LAST) begin
                    py_d = '0;
                    cy_d = cy_q + CYW'(1);
                    rb_d = rb_q + RBW'(COLS);
                end else begin
                    py_d = py_q + PW'(1);
                end
            end
        end

        ctl0.act  = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
        ctl0.inb  = h_in && v_in;
        ctl0.grid = (px_q == '0) || (py_q == '0);
        ctl0.bord = (hcnt_q >= H_BL0) && (hcnt_q < H_BL1) && (vcnt_q >= V_BL0) && (vcnt_q < V_BL1);
        ctl0.hs   = !((hcnt_q >= H_S0) && (hcnt_q < H_S1));
        ctl0.vs   = !((vcnt_q >= V_S0) && (vcnt_q < V_S1));
        ctl0.ft   = (hcnt_q == '0) && (vcnt_q == V_ACT);

        addr_d = ctl0.inb ? 9'(rb_q) + 9'(cx_q) : 9'(BLANK_ADDR);
    end

    always_comb begin
        rgb_d = 12'h000;
        if (!ctl2_q.act) begin
            rgb_d = 12'h000;
        end else if (ctl2_q.inb && ctl2_q.grid) begin
            rgb_d = 12'h000;
        end else if (ctl2_q.inb) begin
            rgb_d = mem_dout;
        end else if (ctl2_q.bord) begin
            rgb_d = 12'hfff;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hcnt_q <= '0;
            vcnt_q <= '0;
            px_q   <= '0;
            cx_q   <= '0;
            py_q   <= '0;
            cy_q   <= '0;
            rb_q   <= '0;
            addr_q <= 9'(BLANK_ADDR);
            ctl1_q <= CTL_IDLE;
            ctl2_q <= CTL_IDLE;
            rgb_q  <= '0;
            hs_q   <= 1'b1;
            vs_q   <= 1'b1;
            de_q   <= 1'b0;
            ft_q   <= 1'b0;
        end else begin
            hcnt_q <= hcnt_d;
            vcnt_q <= vcnt_d;
            px_q   <= px_d;
            cx_q   <= cx_d;
            py_q   <= py_d;
            cy_q   <= cy_d;
            rb_q   <= rb_d;
            addr_q <= addr_d;
            ctl1_q <= ctl0;
            ctl2_q <= ctl1_q;
            rgb_q  <= rgb_d;
            hs_q   <= ctl2_q.hs;
            vs_q   <= ctl2_q.vs;
            de_q   <= ctl2_q.act;
            ft_q   <= ctl2_q.ft;
        end
    end

    assign addr_r     = addr_q;
    assign vga_r      = rgb_q[11:8];
    assign vga_g      = rgb_q[7:4];
    assign vga_b      = rgb_q[3:0];
    assign hsync      = hs_q;
    assign vsync      = vs_q;
    assign de         = de_q;
    assign frame_tick = ft_q;

endmodule

// File: tb/tb_tetris_vga_render.sv
// Bench for tetris_vga_render: full-size instance under a per-cycle scoreboard plus vector table,
// and a shrunken-timing instance for whole-frame sync and tick periods.
module tb_tetris_vga_render;

    logic clk = 1'b0;
    always #20 clk = ~clk;

    logic        rst, rst_s;
    logic [11:0] mem_dout, s_mem;
    logic [8:0]  addr_r, s_addr;
    logic [3:0]  vga_r, vga_g, vga_b, s_r, s_g, s_b;
    logic        hsync, vsync, de, frame_tick;
    logic        s_hs, s_vs, s_de, s_ft;
    logic [15:0] obs;

    assign obs = {vga_r, vga_g, vga_b, de, hsync, vsync, frame_tick};

    tetris_vga_render u_dut (
        .clk(clk), .rst(rst), .mem_dout(mem_dout), .addr_r(addr_r),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .hsync(hsync), .vsync(vsync), .de(de), .frame_tick(frame_tick)
    );

    // 50x37 raster, 4x5 board of 2x2 cells at (10,4): one frame is 1850 clocks.
    tetris_vga_render #(
        .H_ACTIVE(40), .H_FP(2), .H_SYNC(4), .H_BP(4),
        .V_ACTIVE(30), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .CELL(2), .COLS(4), .ROWS(5), .BOARD_X0(10), .BOARD_Y0(4),
        .BORDER_W(2), .BLANK_ADDR(20)
    ) u_small (
        .clk(clk), .rst(rst_s), .mem_dout(s_mem), .addr_r(s_addr),
        .vga_r(s_r), .vga_g(s_g), .vga_b(s_b),
        .hsync(s_hs), .vsync(s_vs), .de(s_de), .frame_tick(s_ft)
    );

    always @(posedge clk) begin
        mem_dout <= (addr_r == 9'd13) ? 12'hf00 : 12'h666;
        s_mem    <= {3'b000, s_addr};
    end

    int total = 0;
    int bad   = 0;
    int k     = 0;
    logic [15:0] exp_q[$];
    localparam logic [15:0] INACT = 16'h0006;

    task automatic chk(input string name, input int x, input int y,
                       input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s x=%0d y=%0d got=%h want=%h", name, x, y, got, want);
        end
    endtask

    function automatic logic [11:0] mem_col(input int a);
        return (a == 13) ? 12'hf00 : 12'h666;
    endfunction

    function automatic logic [8:0] ref_addr(input int x, input int y);
        if (x >= 220 && x < 420 && y >= 30 && y < 450)
            return 9'(((y - 30) / 20) * 10 + (x - 220) / 20);
        return 9'd210;
    endfunction

    function automatic logic [15:0] ref_out(input int x, input int y);
        logic [11:0] rgb;
        logic act, inb, brd;
        act = (x < 640) && (y < 480);
        inb = (x >= 220) && (x < 420) && (y >= 30) && (y < 450);
        brd = (x >= 218) && (x < 422) && (y >= 28) && (y < 452);
        rgb = 12'h000;
        if (act && inb) begin
            if (((x - 220) % 20 != 0) && ((y - 30) % 20 != 0))
                rgb = mem_col(((y - 30) / 20) * 10 + (x - 220) / 20);
        end else if (act && brd) begin
            rgb = 12'hfff;
        end
        return {rgb, act, !((x >= 656) && (x < 752)), !((y >= 490) && (y < 492)),
                (x == 0) && (y == 480)};
    endfunction

    // Sample k-1 is the one whose address is visible now; outputs lag two more clocks.
    int m_s, m_x, m_y, m_x3, m_y3;
    logic [15:0] m_e;
    always @(posedge clk) begin
        #1;
        if (rst) begin
            k = 0;
            exp_q.delete();
            exp_q.push_back(INACT);
            exp_q.push_back(INACT);
            chk("rst_addr", -1, -1, 32'(addr_r), 32'd210);
            chk("rst_out", -1, -1, 32'(obs), 32'(INACT));
        end else begin
            k = k + 1;
            m_s = k - 1;
            m_x = m_s % 800;
            m_y = (m_s / 800) % 525;
            chk("addr", m_x, m_y, 32'(addr_r), 32'(ref_addr(m_x, m_y)));
            exp_q.push_back(ref_out(m_x, m_y));
            m_e = exp_q.pop_front();
            m_s = k - 3;
            m_x3 = (m_s < 0) ? -1 : m_s % 800;
            m_y3 = (m_s < 0) ? -1 : (m_s / 800) % 525;
            chk("pix", m_x3, m_y3, 32'(obs), 32'(m_e));
        end
    end

    typedef struct {
        int          x;
        int          y;
        logic [8:0]  addr;
        logic [11:0] rgb;
        logic        de;
    } vec_t;

    localparam int NV = 11;
    vec_t vecs[NV];

    int ia, io, guard, hs_c;
    int ft1, ft2, n_ft, vs_low, vs_first, hs_low, hs_first;
    logic [8:0]  sa_blank, sa_first, sa_last;
    logic [11:0] s_rgb;
    logic        s_de_v;

    initial begin
        vecs[0]  = '{220, 30, 9'd0,   12'h000, 1'b1};
        vecs[1]  = '{239, 30, 9'd0,   12'h000, 1'b1};
        vecs[2]  = '{240, 30, 9'd1,   12'h000, 1'b1};
        vecs[3]  = '{100, 40, 9'd210, 12'h000, 1'b1};
        vecs[4]  = '{217, 40, 9'd210, 12'h000, 1'b1};
        vecs[5]  = '{218, 40, 9'd210, 12'hfff, 1'b1};
        vecs[6]  = '{421, 40, 9'd210, 12'hfff, 1'b1};
        vecs[7]  = '{700, 40, 9'd210, 12'h000, 1'b0};
        vecs[8]  = '{280, 55, 9'd13,  12'h000, 1'b1};
        vecs[9]  = '{285, 55, 9'd13,  12'hf00, 1'b1};
        vecs[10] = '{305, 55, 9'd14,  12'h666, 1'b1};

        rst   = 1'b1;
        rst_s = 1'b1;
        repeat (3) @(negedge clk);

        // Shrunken instance: two frames of sync and tick timing.
        ft1 = -1; ft2 = -1; n_ft = 0; vs_low = 0; vs_first = -1; hs_low = 0; hs_first = -1;
        sa_blank = '0; sa_first = '0; sa_last = '0; s_rgb = '0; s_de_v = 1'b0;
        @(negedge clk);
        rst_s = 1'b0;
        for (int c = 1; c <= 3800; c++) begin
            @(posedge clk);
            #2;
            if (s_ft) begin
                n_ft++;
                if (n_ft == 1) ft1 = c;
                if (n_ft == 2) ft2 = c;
            end
            if (!s_vs) begin
                vs_low++;
                if (vs_first < 0) vs_first = c;
            end
            if (c <= 52 && !s_hs) begin
                hs_low++;
                if (hs_first < 0) hs_first = c;
            end
            if (c == 210) sa_blank = s_addr;
            if (c == 211) sa_first = s_addr;
            if (c == 668) sa_last = s_addr;
            if (c == 266) begin
                s_rgb  = {s_r, s_g, s_b};
                s_de_v = s_de;
            end
        end
        chk("s_ft_first", -1, -1, 32'(ft1), 32'd1503);
        chk("s_ft_period", -1, -1, 32'(ft2 - ft1), 32'd1850);
        chk("s_ft_count", -1, -1, 32'(n_ft), 32'd2);
        chk("s_vs_first", -1, -1, 32'(vs_first), 32'd1603);
        chk("s_vs_low", -1, -1, 32'(vs_low), 32'd200);
        chk("s_hs_first", -1, -1, 32'(hs_first), 32'd45);
        chk("s_hs_low", -1, -1, 32'(hs_low), 32'd4);
        chk("s_addr_blank", 9, 4, 32'(sa_blank), 32'd20);
        chk("s_addr_first", 10, 4, 32'(sa_first), 32'd0);
        chk("s_addr_last", 17, 13, 32'(sa_last), 32'd19);
        chk("s_rgb", 13, 5, 32'(s_rgb), 32'h001);
        chk("s_de", 13, 5, 32'(s_de_v), 32'd1);

        // Full-size instance: run, then a 3-cycle reset mid-frame.
        @(negedge clk);
        rst = 1'b0;
        repeat (1500) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        ia = 0; io = 0; guard = 0;
        while ((ia < NV || io < NV) && guard < 60000) begin
            @(posedge clk);
            #2;
            guard++;
            if (ia < NV && k == vecs[ia].y * 800 + vecs[ia].x + 1) begin
                chk("vec_addr", vecs[ia].x, vecs[ia].y, 32'(addr_r), 32'(vecs[ia].addr));
                ia++;
            end
            if (io < NV && k == vecs[io].y * 800 + vecs[io].x + 3) begin
                chk("vec_rgb", vecs[io].x, vecs[io].y, 32'({vga_r, vga_g, vga_b}), 32'(vecs[io].rgb));
                chk("vec_de", vecs[io].x, vecs[io].y, 32'(de), 32'(vecs[io].de));
                io++;
            end
        end
        chk("vec_done", -1, -1, 32'(ia + io), 32'(2 * NV));

        // Single-cycle reset while the counters sit at (400,57).
        guard = 0;
        while (k != 57 * 800 + 400 && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        chk("mid_rst_sync", 400, 57, 32'(k), 32'(57 * 800 + 400));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        hs_c = 0;
        for (int c = 1; c <= 1000; c++) begin
            @(posedge clk);
            #2;
            if (!hsync && hs_c == 0) hs_c = c;
        end
        chk("hs_after_rst", -1, -1, 32'(hs_c), 32'd659);
        repeat (700) @(posedge clk);
        #2;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
